// File: rtl/icache_refill_ctrl_if.sv
// Signal bundle between the L1I refill controller and its cache / lower-memory neighbours.
// master = the refill controller, slave = the cache + memory side.
interface icache_refill_ctrl_if #(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 256,
  parameter int BEAT_W  = 64
);
  logic               miss_i;
  logic [ADDR_W-1:0]  missAddr_i;
  logic               memReqValid_o;
  logic               memReqReady_i;
  logic [ADDR_W-1:0]  memReqAddr_o;
  logic               memRespValid_i;
  logic [BEAT_W-1:0]  memRespData_i;
  logic               wrEnable_o;
  logic [ADDR_W-1:0]  wrAddr_o;
  logic [BLOCK_W-1:0] instBlock_o;
  logic               busy_o;

  modport master (
    input  miss_i, missAddr_i, memReqReady_i, memRespValid_i, memRespData_i,
    output memReqValid_o, memReqAddr_o, wrEnable_o, wrAddr_o, instBlock_o, busy_o
  );

  modport slave (
    output miss_i, missAddr_i, memReqReady_i, memRespValid_i, memRespData_i,
    input  memReqValid_o, memReqAddr_o, wrEnable_o, wrAddr_o, instBlock_o, busy_o
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// L1 instruction-cache miss refill sequencer: one block request, beat assembly, single-cycle fill.
// One refill in flight; once a miss is accepted the refill always runs to completion.
module icache_refill_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int BLOCK_W     = 256,
  parameter int BEAT_W      = 64,
  parameter int OFFSET_BITS = 5
) (
  input logic                  clk,
  input logic                  reset,
  icache_refill_ctrl_if.master bus
);
  localparam int NBEATS = BLOCK_W / BEAT_W;
  localparam int CNT_W  = $clog2(NBEATS);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFFSET_BITS) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RECV,
    S_WRITE,
    S_COOL
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BLOCK_W-1:0]   r_buf;
  logic                 r_req_valid;
  logic [ADDR_W-1:0]    r_req_addr;
  logic                 r_wr_en;
  logic [ADDR_W-1:0]    r_wr_addr;
  logic [BLOCK_W-1:0]   r_inst_block;
  logic                 r_busy;

  logic [ADDR_W-1:0]    w_align;
  logic [BLOCK_W-1:0]   w_block;
  logic                 w_last_beat;

  assign w_align     = bus.missAddr_i & ~OFF_MASK;
  assign w_last_beat = (r_cnt == CNT_W'(NBEATS - 1));

  // Beats are staged in r_buf so instBlock_o only changes on the fill cycle.
  always_comb begin
    w_block = r_buf;
    w_block[int'(r_cnt) * BEAT_W +: BEAT_W] = bus.memRespData_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_buf        <= '0;
      r_req_valid  <= 1'b0;
      r_req_addr   <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_inst_block <= '0;
      r_busy       <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.miss_i) begin
            r_req_addr  <= w_align;
            r_req_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.memReqReady_i) begin
            r_req_valid <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_RECV;
          end
        end
        S_RECV: begin
          if (bus.memRespValid_i) begin
            r_buf <= w_block;
            r_cnt <= r_cnt + 1'b1;
            if (w_last_beat) begin
              r_inst_block <= w_block;
              r_wr_addr    <= r_req_addr;
              r_wr_en      <= 1'b1;
              r_state      <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_wr_en <= 1'b0;
          r_state <= S_COOL;
        end
        S_COOL: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.memReqValid_o = r_req_valid;
  assign bus.memReqAddr_o  = r_req_addr;
  assign bus.wrEnable_o    = r_wr_en;
  assign bus.wrAddr_o      = r_wr_addr;
  assign bus.instBlock_o   = r_inst_block;
  assign bus.busy_o        = r_busy;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomised scoreboard bench for icache_refill_ctrl: expected requests and fills are queued
// by the stimulus side and popped/compared by an independent monitor.
module tb_icache_refill_ctrl;
  localparam int ADDR_W  = 32;
  localparam int BLOCK_W = 256;
  localparam int BEAT_W  = 64;
  localparam int NB      = BLOCK_W / BEAT_W;

  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [BLOCK_W-1:0] blk;
    int                 cyc;
  } fill_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   cyc;
  int   fills_done;

  logic [ADDR_W-1:0] req_q[$];
  fill_t             fill_q[$];

  icache_refill_ctrl_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .BEAT_W(BEAT_W)) bus ();

  icache_refill_ctrl #(
    .ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .BEAT_W(BEAT_W), .OFFSET_BITS(5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [BLOCK_W-1:0] act, input logic [BLOCK_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return a & ~32'h0000_001F;
  endfunction

  // Monitor: request address must match the queued head every cycle it is offered,
  // and every fill strobe must match the next expected block, address and cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.memReqValid_o) begin
        if (req_q.size() == 0) chk("unexpected_req", 1'b1, 1'b0);
        else begin
          chk("req_addr", bus.memReqAddr_o, req_q[0]);
          if (bus.memReqReady_i) void'(req_q.pop_front());
        end
      end
      if (bus.wrEnable_o) begin
        if (fill_q.size() == 0) chk("unexpected_wr", 1'b1, 1'b0);
        else begin
          fill_t f;
          f = fill_q.pop_front();
          chk("wr_addr", bus.wrAddr_o, f.addr);
          chk("inst_block", bus.instBlock_o, f.blk);
          chk("fill_cycle", cyc, f.cyc);
          fills_done++;
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},    bus.busy_o, '0);
    chk({tag, "_reqv"},    bus.memReqValid_o, '0);
    chk({tag, "_reqaddr"}, bus.memReqAddr_o, '0);
    chk({tag, "_wren"},    bus.wrEnable_o, '0);
    chk({tag, "_wraddr"},  bus.wrAddr_o, '0);
    chk({tag, "_block"},   bus.instBlock_o, '0);
  endtask

  task automatic rand_beat();
    bus.memRespValid_i = 1'($urandom_range(0, 1));
    bus.memRespData_i  = {$urandom, $urandom};
  endtask

  // mode: 0 miss pulse, 1 miss held through COOL, 2 miss dropped mid-RECV, 3 reset during beat 2
  task automatic refill(input logic [ADDR_W-1:0] addr, input int rdy_dly, input int gap,
                        input int mode, input logic [BLOCK_W-1:0] data);
    int   f0;
    int   g;
    logic ok;
    f0 = fills_done;
    bus.miss_i     = 1'b1;
    bus.missAddr_i = addr;
    rand_beat();
    req_q.push_back(align(addr));
    @(posedge clk); #1;
    chk("busy_in_req", bus.busy_o, 1'b1);
    if (mode == 0 || mode == 3) begin
      bus.miss_i     = 1'b0;
      bus.missAddr_i = $urandom;
    end
    for (int k = 0; k < rdy_dly; k++) begin
      bus.memRespValid_i = 1'b1;
      bus.memRespData_i  = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    bus.memReqReady_i = 1'b1;
    rand_beat();
    ok = 1'b0;
    for (int k = 0; k < 8 && !ok; k++) begin
      @(negedge clk);
      ok = bus.memReqValid_o;
      @(posedge clk); #1;
    end
    bus.memReqReady_i  = 1'b0;
    bus.memRespValid_i = 1'b0;
    if (!ok) chk("req_timeout", 1'b0, 1'b1);
    for (int i = 0; i < NB; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int k = 0; k < g; k++) begin
        bus.memRespValid_i = 1'b0;
        bus.memRespData_i  = {$urandom, $urandom};
        @(posedge clk); #1;
      end
      bus.memRespValid_i = 1'b1;
      bus.memRespData_i  = data[i*BEAT_W +: BEAT_W];
      if (mode == 3 && i == 2) reset = 1'b1;
      if (mode != 3 && i == NB - 1) fill_q.push_back('{align(addr), data, cyc + 1});
      @(posedge clk); #1;
      if (mode == 3 && i == 2) begin
        reset = 1'b0;
        check_all_zero("mid_reset");
      end
      if (mode == 2 && i == 1) bus.miss_i = 1'b0;
    end
    bus.memRespValid_i = 1'b0;
    if (mode == 3) begin
      repeat (4) @(posedge clk);
      #1;
      chk("no_fill_after_reset", fills_done, f0);
      return;
    end
    rand_beat();
    chk("busy_in_write", bus.busy_o, 1'b1);
    @(posedge clk); #1;
    rand_beat();
    chk("busy_in_cool", bus.busy_o, 1'b1);
    @(posedge clk); #1;
    chk("busy_after_cool", bus.busy_o, 1'b0);
    bus.miss_i         = 1'b0;
    bus.memRespValid_i = 1'b0;
    chk("fill_count", fills_done, f0 + 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      rand_beat();
      @(posedge clk); #1;
    end
    bus.memRespValid_i = 1'b0;
  endtask

  function automatic logic [BLOCK_W-1:0] rand_block();
    logic [BLOCK_W-1:0] b;
    for (int i = 0; i < BLOCK_W / 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    fills_done = 0;
    reset = 1'b1;
    bus.miss_i         = 1'b0;
    bus.missAddr_i     = '0;
    bus.memReqReady_i  = 1'b0;
    bus.memRespValid_i = 1'b0;
    bus.memRespData_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    refill(32'h0000_1234, 0, 0, 0,
           {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
            64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});
    idle_cycles(2);
    refill($urandom, 5, 0, 0, rand_block());
    idle_cycles(1);
    refill($urandom, 1, 2, 0, rand_block());
    refill($urandom, 2, 1, 1, rand_block());
    idle_cycles(2);
    refill($urandom, 0, 1, 2, rand_block());
    idle_cycles(2);
    refill($urandom, 1, 0, 3, rand_block());
    refill(32'h0000_2000, 0, 0, 0, rand_block());

    for (int t = 0; t < 40; t++) begin
      idle_cycles(int'($urandom_range(0, 3)));
      refill($urandom, int'($urandom_range(0, 4)), -1, int'($urandom_range(0, 3)), rand_block());
    end

    idle_cycles(3);
    chk("req_q_drained", req_q.size(), 0);
    chk("fill_q_drained", fill_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
